// File: rtl/dlx_bus_pkg.sv
// rtl/dlx_bus_pkg.sv - shared state encodings and constants for the DLX bus responder
package dlx_bus_pkg;

  localparam int          DLX_DATA_W = 32;
  localparam int          DLX_ADDR_W = 10;
  localparam logic [31:0] DLX_POISON = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } resp_state_e;

endpackage

// File: rtl/dlx_resp_mem.sv
// rtl/dlx_resp_mem.sv - single-port word store with one write port and a registered read
module dlx_resp_mem
  import dlx_bus_pkg::*;
#(
  parameter int DATA_W = DLX_DATA_W,
  parameter int ADDR_W = DLX_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic              poison,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Read data holds until the next read, so writes never disturb it.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = poison ? DATA_W'(DLX_POISON) : mem_q[addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dlx_bus_responder.sv
// rtl/dlx_bus_responder.sv - DLX bus memory slave with wait states and a host load port
// Optional out-of-range checking is enabled by defining DLX_RESP_ADDR_CHECK_EN.
module dlx_bus_responder
  import dlx_bus_pkg::*;
#(
  parameter int DATA_W      = DLX_DATA_W,
  parameter int ADDR_W      = DLX_ADDR_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              AS_N,
  input  logic              WR_N,
  input  logic [31:0]       ADDR,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              ACK_N,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              addr_err,
  output logic [1:0]        RESP_STATE_OUT
);

  resp_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_n_q, wr_n_d;
  logic              oor_q, oor_d;
  logic              ack_n_q, ack_n_d;
  logic              err_q, err_d;

  logic              addr_oor;
  logic              accept;
  logic              access;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

`ifdef DLX_RESP_ADDR_CHECK_EN
  assign addr_oor = |ADDR[31:ADDR_W];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = |ADDR[31:ADDR_W];
  assign addr_oor       = 1'b0;
`endif

  // A host load in IDLE takes priority; the strobe is picked up once load_en drops.
  assign accept = (state_q == ST_IDLE) && !load_en && !AS_N;
  assign access = (state_q == ST_WAIT) && (cnt_q == 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_n_q  <= 1'b1;
      oor_q   <= 1'b0;
      ack_n_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_n_q  <= wr_n_d;
      oor_q   <= oor_d;
      ack_n_q <= ack_n_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_n_d  = wr_n_q;
    oor_d   = oor_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          idx_d   = ADDR[ADDR_W-1:0];
          wdata_d = DIN;
          wr_n_d  = WR_N;
          oor_d   = addr_oor;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_ACK:     state_d = ST_RELEASE;
      ST_RELEASE: if (AS_N) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_n_d   = !access;
    err_d     = err_q | (access & oor_q);
    mem_we    = ((state_q == ST_IDLE) && load_en) || (access && !wr_n_q && !oor_q);
    mem_re    = access && wr_n_q;
    mem_addr  = (state_q == ST_IDLE) ? load_addr : idx_q;
    mem_wdata = (state_q == ST_IDLE) ? load_data : wdata_q;
  end

  dlx_resp_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .we     (mem_we),
    .re     (mem_re),
    .poison (oor_q),
    .addr   (mem_addr),
    .wdata  (mem_wdata),
    .rdata  (DOUT)
  );

  assign ACK_N          = ack_n_q;
  assign addr_err       = err_q;
  assign RESP_STATE_OUT = state_q;

endmodule

// File: tb/tb_dlx_bus_responder.sv
// tb/tb_dlx_bus_responder.sv - randomized scoreboard bench for dlx_bus_responder
module tb_dlx_bus_responder;
  import dlx_bus_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int WAITC = 2;
  localparam int DEPTH = 2**AW;

  logic          clk;
  logic          reset;
  logic          AS_N;
  logic          WR_N;
  logic [31:0]   ADDR;
  logic [DW-1:0] DIN;
  logic [DW-1:0] DOUT;
  logic          ACK_N;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          addr_err;
  logic [1:0]    RESP_STATE_OUT;

  dlx_bus_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WAITC)) dut (
    .clk            (clk),
    .reset          (reset),
    .AS_N           (AS_N),
    .WR_N           (WR_N),
    .ADDR           (ADDR),
    .DIN            (DIN),
    .DOUT           (DOUT),
    .ACK_N          (ACK_N),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .addr_err       (addr_err),
    .RESP_STATE_OUT (RESP_STATE_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] last_rd;
  logic        mdl_err;

  typedef struct {
    logic [31:0] dout;
    logic        err;
    string       name;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: word index is the address modulo depth; out-of-range only with the check build.
  task automatic model_access(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    bit oor;
    exp_t e;
`ifdef DLX_RESP_ADDR_CHECK_EN
    oor = (addr[31:AW] != 0);
`else
    oor = 1'b0;
`endif
    if (oor) begin
      mdl_err = 1'b1;
      if (!wr) last_rd = DLX_POISON;
    end else if (wr) begin
      mdl_mem[addr % DEPTH] = data;
    end else begin
      last_rd = mdl_mem[addr % DEPTH];
    end
    e.dout = last_rd;
    e.err  = mdl_err;
    e.name = wr ? "write" : "read";
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset && !ACK_N) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_dout"}, DOUT, mon_e.dout);
        check({mon_e.name, "_addr_err"}, {31'd0, addr_err}, {31'd0, mon_e.err});
      end
    end
  end

  // Called at a negedge with the responder idle; leaves it idle at a negedge.
  task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input int hold, input bit pre_load, input bit scramble);
    int  lat;
    bit  seen;
    logic [AW-1:0] la;
    logic [31:0]   ld;
    AS_N = 1'b0;
    WR_N = !wr;
    ADDR = addr;
    DIN  = data;
    if (pre_load) begin
      la = AW'($urandom_range(0, 31));
      ld = $urandom;
      load_en   = 1'b1;
      load_addr = la;
      load_data = ld;
      mdl_mem[la] = ld;
      @(negedge clk);
      check("load_defers_req", {30'd0, RESP_STATE_OUT}, 32'd0);
      load_en = 1'b0;
    end
    model_access(wr, addr, data);
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (!ACK_N) begin
        seen = 1'b1;
        lat  = i;
      end else if (scramble && i == 0) begin
        WR_N = 1'($urandom);
        ADDR = $urandom;
        DIN  = $urandom;
      end
    end
    if (!seen) begin
      check("ack_timeout", 32'd0, 32'd1);
      AS_N = 1'b1;
      return;
    end
    check("ack_latency", lat, WAITC + 1);
    for (int j = 0; j < hold; j++) begin
      if ($urandom_range(0, 1) == 1) begin
        load_en   = 1'b1;
        load_addr = AW'($urandom_range(0, 31));
        load_data = $urandom;
      end
      @(negedge clk);
      load_en = 1'b0;
      check("hold_state", {30'd0, RESP_STATE_OUT}, 32'd3);
      check("hold_single_ack", {31'd0, ACK_N}, 32'd1);
    end
    AS_N = 1'b1;
    @(negedge clk);
    if (hold == 0) begin
      check("release_state", {30'd0, RESP_STATE_OUT}, 32'd3);
      @(negedge clk);
    end
    check("back_to_idle", {30'd0, RESP_STATE_OUT}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    AS_N      = 1'b1;
    WR_N      = 1'b1;
    ADDR      = '0;
    DIN       = '0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    last_rd   = '0;
    mdl_err   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ack_n", {31'd0, ACK_N}, 32'd1);
    check("reset_dout", DOUT, 32'd0);
    check("reset_addr_err", {31'd0, addr_err}, 32'd0);
    check("reset_state", {30'd0, RESP_STATE_OUT}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_data = (i == 5) ? 32'h12345678 : $urandom;
      mdl_mem[i] = load_data;
      @(negedge clk);
    end
    load_en = 1'b0;
    @(negedge clk);

    do_access(1'b0, 32'd5, 32'd0, 1, 1'b0, 1'b0);
    check("plan_read5", DOUT, 32'h12345678);
    do_access(1'b1, 32'd7, 32'hA5A5A5A5, 1, 1'b0, 1'b0);
    do_access(1'b0, 32'd7, 32'd0, 0, 1'b0, 1'b0);
    do_access(1'b1, 32'd8, 32'h0BADF00D, 2, 1'b0, 1'b1);
    check("write_keeps_dout", DOUT, 32'hA5A5A5A5);
    do_access(1'b0, 32'd8, 32'd0, 6, 1'b0, 1'b0);
    do_access(1'b0, 32'd1029, 32'd0, 1, 1'b0, 1'b0);
    do_access(1'b1, 32'h400, 32'hCAFEF00D, 1, 1'b0, 1'b0);
    do_access(1'b0, 32'h400, 32'd0, 1, 1'b0, 1'b0);
    do_access(1'b0, 32'd0, 32'd0, 1, 1'b0, 1'b0);

    AS_N = 1'b0;
    WR_N = 1'b0;
    ADDR = 32'd3;
    DIN  = ~mdl_mem[3];
    @(negedge clk);
    check("wr3_in_wait", {30'd0, RESP_STATE_OUT}, 32'd1);
    reset = 1'b0;
    #1;
    check("midreset_ack_n", {31'd0, ACK_N}, 32'd1);
    check("midreset_state", {30'd0, RESP_STATE_OUT}, 32'd0);
    check("midreset_dout", DOUT, 32'd0);
    check("midreset_addr_err", {31'd0, addr_err}, 32'd0);
    AS_N = 1'b1;
    @(negedge clk);
    reset   = 1'b1;
    last_rd = '0;
    mdl_err = 1'b0;
    @(negedge clk);
    do_access(1'b0, 32'd3, 32'd0, 1, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = $urandom_range(0, 31);
      if ($urandom_range(0, 5) == 0) a[31:AW] = 22'($urandom);
      do_access(1'($urandom), a, $urandom, $urandom_range(0, 3),
                $urandom_range(0, 7) == 0, 1'($urandom));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
